// File: rtl/joy_sega6_reader_pkg.sv
// Shared constants for the DB9 joystick reader: protocol phase numbers,
// button bit positions in the MXYZ SACB RLDU vector, and pad-decode helpers.
package joy_pkg;

    typedef logic [11:0] joy_vec_t;
    typedef logic [5:0]  pin_vec_t;

    // Phases (tick numbers within a 256-tick frame) that carry an action.
    localparam logic [7:0] PH_P7_LO0   = 8'd0;
    localparam logic [7:0] PH_P7_HI0   = 8'd1;
    localparam logic [7:0] PH_READ_DIR = 8'd2;
    localparam logic [7:0] PH_READ_SA  = 8'd3;
    localparam logic [7:0] PH_P7_LO2   = 8'd4;
    localparam logic [7:0] PH_SIX_CHK  = 8'd5;
    localparam logic [7:0] PH_READ_XYZ = 8'd6;

    // Bit positions in the button vector {M,X,Y,Z,S,A,C,B,R,L,D,U}.
    localparam int JB_U = 0;
    localparam int JB_D = 1;
    localparam int JB_L = 2;
    localparam int JB_R = 3;
    localparam int JB_B = 4;
    localparam int JB_C = 5;
    localparam int JB_A = 6;
    localparam int JB_S = 7;
    localparam int JB_Z = 8;
    localparam int JB_Y = 9;
    localparam int JB_X = 10;
    localparam int JB_M = 11;

    // Raw pin positions {p9,p6,right,left,down,up}.
    localparam int PIN_U  = 0;
    localparam int PIN_L  = 2;
    localparam int PIN_R  = 3;
    localparam int PIN_P6 = 4;
    localparam int PIN_P9 = 5;

    // Every button released.
    localparam joy_vec_t JOY_NONE = 12'hFFF;

    // A Mega Drive pad pulls both left and right low while select is low.
    function automatic logic is_md_pad(input pin_vec_t pins);
        return (pins[PIN_R] == 1'b0) && (pins[PIN_L] == 1'b0);
    endfunction

    // A 6-button pad pulls all four directions low on the third select-low.
    function automatic logic is_six_cand(input pin_vec_t pins);
        return (pins[PIN_R:PIN_U] == 4'b0000);
    endfunction

endpackage

// File: rtl/joy_sega6_reader_if.sv
// Pin and button bundle between the joystick reader and its surroundings.
// The master side is the reader (drives select, publishes buttons); the
// slave side is the pads plus the consuming top.
interface joy_sega6_reader_if;
    import joy_pkg::*;

    pin_vec_t joy1_pins_i;
    pin_vec_t joy2_pins_i;
    logic     joy_p7_o;
    joy_vec_t joy1_o;
    joy_vec_t joy2_o;
    logic     joy1_six_o;
    logic     joy2_six_o;
    logic     frame_o;

    modport master (
        input  joy1_pins_i,
        input  joy2_pins_i,
        output joy_p7_o,
        output joy1_o,
        output joy2_o,
        output joy1_six_o,
        output joy2_six_o,
        output frame_o
    );

    modport slave (
        output joy1_pins_i,
        output joy2_pins_i,
        input  joy_p7_o,
        input  joy1_o,
        input  joy2_o,
        input  joy1_six_o,
        input  joy2_six_o,
        input  frame_o
    );

endinterface

// File: rtl/joy_sega6_reader_pin_sync.sv
// Multi-stage synchroniser for the asynchronous DB9 pin inputs. Resets to
// all-ones so an unplugged or still-resetting port reads as released.
module joy_pin_sync #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the raw pins through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b1}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/joy_sega6_reader.sv
// Two-port DB9 reader for Atari, Master System, Mega Drive 3- and 6-button
// pads. A tick divider paces a 256-tick frame; the first seven ticks toggle
// the shared select line and latch the pad responses, the rest idle with
// select high so 6-button pads time out and restart their sequence.
module joy_sega6_reader
    import joy_pkg::*;
#(
    parameter int TICK_DIV    = 1536,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_sys,
    input  logic                reset,
    joy_sega6_reader_if.master  bus
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [11:0]           sync_q;
    logic [1:0][5:0]       pins_s;
    logic                  tick_s;

    logic [15:0]           tick_cnt_r, tick_cnt_s;
    logic [7:0]            phase_r,    phase_s;
    logic                  p7_r,       p7_s;
    logic [1:0][11:0]      joy_r,      joy_s;
    logic [1:0]            cand_r,     cand_s;
    logic [1:0]            six_r,      six_s;
    logic                  frame_r,    frame_s;

    joy_pin_sync #(
        .WIDTH  (12),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_sys),
        .reset (reset),
        .d     ({bus.joy2_pins_i, bus.joy1_pins_i}),
        .q     (sync_q)
    );

    // Port 0 is joy1 (low six bits), port 1 is joy2.
    assign pins_s = sync_q;
    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Next-state: divider, phase counter and the per-phase select/latch actions.
    always_comb begin
        tick_cnt_s = tick_s ? 16'd0 : (tick_cnt_r + 16'd1);
        phase_s    = phase_r;
        p7_s       = p7_r;
        joy_s      = joy_r;
        cand_s     = cand_r;
        six_s      = six_r;
        frame_s    = 1'b0;

        if (tick_s) begin
            phase_s = phase_r + 8'd1;
            case (phase_r)
                PH_P7_LO0: begin
                    p7_s = 1'b0;
                end
                PH_P7_HI0: begin
                    p7_s = 1'b1;
                end
                PH_READ_DIR: begin
                    // Select high: directions plus B on p6 and C on p9.
                    for (int p = 0; p < 2; p++) begin
                        joy_s[p][JB_R:JB_U] = pins_s[p][PIN_R:PIN_U];
                        joy_s[p][JB_C:JB_B] = pins_s[p][PIN_P9:PIN_P6];
                        cand_s[p]           = 1'b0;
                    end
                    p7_s = 1'b0;
                end
                PH_READ_SA: begin
                    // Select low: only a Mega Drive pad reports Start/A here.
                    for (int p = 0; p < 2; p++) begin
                        if (is_md_pad(pins_s[p])) begin
                            joy_s[p][JB_S:JB_A] = pins_s[p][PIN_P9:PIN_P6];
                        end else begin
                            joy_s[p][JB_S:JB_A] = 2'b11;
                        end
                    end
                    p7_s = 1'b1;
                end
                PH_P7_LO2: begin
                    p7_s = 1'b0;
                end
                PH_SIX_CHK: begin
                    for (int p = 0; p < 2; p++) begin
                        cand_s[p] = is_six_cand(pins_s[p]);
                    end
                    p7_s = 1'b1;
                end
                PH_READ_XYZ: begin
                    // Direction pins now carry M,X,Y,Z on a 6-button pad.
                    for (int p = 0; p < 2; p++) begin
                        if (cand_r[p]) begin
                            joy_s[p][JB_M:JB_Z] = pins_s[p][PIN_R:PIN_U];
                        end else begin
                            joy_s[p][JB_M:JB_Z] = 4'hF;
                        end
                        six_s[p] = cand_r[p];
                    end
                    frame_s = 1'b1;
                    p7_s    = 1'b0;
                end
                default: begin
                    p7_s = 1'b1;
                end
            endcase
        end else begin
            phase_s = phase_r;
        end
    end

    // State and output registers; reset restarts the frame with pads released.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= 16'd0;
            phase_r    <= 8'd0;
            p7_r       <= 1'b1;
            joy_r      <= {JOY_NONE, JOY_NONE};
            cand_r     <= 2'b00;
            six_r      <= 2'b00;
            frame_r    <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_s;
            phase_r    <= phase_s;
            p7_r       <= p7_s;
            joy_r      <= joy_s;
            cand_r     <= cand_s;
            six_r      <= six_s;
            frame_r    <= frame_s;
        end
    end

    assign bus.joy_p7_o   = p7_r;
    assign bus.joy1_o     = joy_r[0];
    assign bus.joy2_o     = joy_r[1];
    assign bus.joy1_six_o = six_r[0];
    assign bus.joy2_six_o = six_r[1];
    assign bus.frame_o    = frame_r;

endmodule

// File: tb/tb_joy_sega6_reader.sv
// Bench for joy_sega6_reader: behavioural pad models react to the select
// line, and expected button vectors come straight from the held buttons.
module tb_joy_sega6_reader;

    localparam int TD    = 8;
    localparam int FRAME = 256 * TD;

    localparam int K_NONE = 0;
    localparam int K_MS   = 1;
    localparam int K_MD3  = 2;
    localparam int K_MD6  = 3;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    joy_sega6_reader_if bus();

    joy_sega6_reader #(.TICK_DIV(TD), .SYNC_STAGES(2)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Pad configuration: kind and held buttons (active-low MXYZ SACB RLDU).
    int          kind1 = K_NONE;
    int          kind2 = K_NONE;
    logic [11:0] btn1  = 12'hFFF;
    logic [11:0] btn2  = 12'hFFF;

    // 6-button pad sequencing: counts select falling edges, forgets them
    // after select has been idle high for a while.
    int   n_low  = 0;
    int   hi_run = 0;
    logic p7_q   = 1'b1;

    always @(posedge clk_sys) begin
        p7_q <= bus.joy_p7_o;
        if (p7_q && !bus.joy_p7_o) n_low <= n_low + 1;
        else if (bus.joy_p7_o && hi_run >= 32) n_low <= 0;
        hi_run <= bus.joy_p7_o ? ((hi_run < 1000) ? hi_run + 1 : hi_run) : 0;
    end

    function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                            input logic sel, input int n);
        logic [5:0] r;
        r = 6'h3F;
        case (kind)
            K_MS:  r = {b[5], b[4], b[3:0]};
            K_MD3: r = sel ? {b[5], b[4], b[3:0]} : {b[7], b[6], 2'b00, b[1:0]};
            K_MD6: begin
                if (sel) r = (n == 3) ? {b[5], b[4], b[11:8]} : {b[5], b[4], b[3:0]};
                else if (n == 3) r = {b[7], b[6], 4'h0};
                else if (n == 4) r = {b[7], b[6], 4'hF};
                else r = {b[7], b[6], 2'b00, b[1:0]};
            end
            default: r = 6'h3F;
        endcase
        return r;
    endfunction

    assign bus.joy1_pins_i = pad_pins(kind1, btn1, bus.joy_p7_o, n_low);
    assign bus.joy2_pins_i = pad_pins(kind2, btn2, bus.joy_p7_o, n_low);

    // What a correct reader reports for a pad of this kind holding b.
    function automatic logic [11:0] exp_vec(input int kind, input logic [11:0] b);
        case (kind)
            K_MS:    return {4'hF, 2'b11, b[5:0]};
            K_MD3:   return {4'hF, b[7:0]};
            K_MD6:   return b;
            default: return 12'hFFF;
        endcase
    endfunction

    // Random buttons with physically possible directions (no U+D or L+R).
    function automatic logic [11:0] rand_btn();
        logic [11:0] b;
        logic [1:0]  ax [2];
        b = 12'($urandom);
        for (int i = 0; i < 2; i++) begin
            case ($urandom_range(0, 2))
                0:       ax[i] = 2'b11;
                1:       ax[i] = 2'b10;
                default: ax[i] = 2'b01;
            endcase
        end
        b[3:0] = {ax[1], ax[0]};
        return b;
    endfunction

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_frame(output int cycles);
        cycles = 0;
        while (cycles < 3 * FRAME) begin
            @(negedge clk_sys);
            cycles++;
            if (bus.frame_o === 1'b1) return;
        end
        cycles = -1;
    endtask

    // Skip one frame (pads may have changed mid-frame), check the next.
    task automatic check_frame(input string tag, input logic [11:0] e1, input logic [11:0] e2,
                               input logic s1, input logic s2);
        int c;
        wait_frame(c);
        chk({tag, "_frame_a"}, 32'(c > 0), 32'd1);
        wait_frame(c);
        chk({tag, "_frame_b"}, 32'(c > 0), 32'd1);
        chk({tag, "_joy1"}, 32'(bus.joy1_o), 32'(e1));
        chk({tag, "_joy2"}, 32'(bus.joy2_o), 32'(e2));
        chk({tag, "_six1"}, 32'(bus.joy1_six_o), 32'(s1));
        chk({tag, "_six2"}, 32'(bus.joy2_six_o), 32'(s2));
    endtask

    initial begin
        int c;
        int ph;
        int prev;
        logic [11:0] b;

        // Reset state.
        repeat (3) @(negedge clk_sys);
        chk("rst_joy1", 32'(bus.joy1_o), 32'h FFF);
        chk("rst_joy2", 32'(bus.joy2_o), 32'h FFF);
        chk("rst_p7", 32'(bus.joy_p7_o), 32'd1);
        chk("rst_six", 32'({bus.joy1_six_o, bus.joy2_six_o}), 32'd0);
        chk("rst_frame", 32'(bus.frame_o), 32'd0);
        reset = 1'b0;

        // No pads: first frame after 7 ticks, then one per 256 ticks.
        wait_frame(c);
        chk("first_frame_cycles", 32'(c), 32'(7 * TD));
        wait_frame(c);
        chk("frame_period", 32'(c), 32'(FRAME));
        chk("idle_joy1", 32'(bus.joy1_o), 32'h FFF);
        chk("idle_joy2", 32'(bus.joy2_o), 32'h FFF);
        chk("idle_six", 32'({bus.joy1_six_o, bus.joy2_six_o}), 32'd0);

        // Select line over a full frame plus wrap, one sample per tick.
        // Now in the first cycle of phase interval 7.
        for (int j = 0; j <= 256; j++) begin
            ph   = (7 + j) % 256;
            prev = (ph + 255) % 256;
            chk($sformatf("p7_ph%0d", ph), 32'(bus.joy_p7_o),
                32'((prev <= 6) ? (prev % 2) : 1));
            repeat (TD) @(negedge clk_sys);
        end

        // 3-button Mega Drive pad, A and Up held.
        kind1 = K_MD3;
        btn1  = 12'hFBE;
        check_frame("md3_a_up", 12'hFBE, 12'hFFF, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            btn1 = rand_btn();
            check_frame($sformatf("md3_rnd%0d", i), exp_vec(K_MD3, btn1), 12'hFFF, 1'b0, 1'b0);
        end

        // 6-button pad, X and C held, port 2 empty.
        kind1 = K_MD6;
        btn1  = 12'hBDF;
        check_frame("md6_x_c", 12'hBDF, 12'hFFF, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            kind1 = K_MS;
            btn1  = rand_btn();
            kind2 = K_MD6;
            btn2  = rand_btn();
            check_frame($sformatf("ms_md6_rnd%0d", i), exp_vec(K_MS, btn1),
                        exp_vec(K_MD6, btn2), 1'b0, 1'b1);
        end

        // Master System pad with button 1 (p6) held.
        kind1 = K_MS;
        btn1  = 12'hFEF;
        kind2 = K_NONE;
        btn2  = 12'hFFF;
        check_frame("ms_p6", 12'hFEF, 12'hFFF, 1'b0, 1'b0);

        // Reset in the middle of phase 4 with a 6-button pad attached.
        kind1 = K_MD6;
        b     = rand_btn();
        btn1  = b;
        check_frame("md6_pre_rst", exp_vec(K_MD6, b), 12'hFFF, 1'b1, 1'b0);
        repeat (253 * TD + 3) @(negedge clk_sys);
        reset = 1'b1;
        #1;
        chk("midrst_joy1", 32'(bus.joy1_o), 32'h FFF);
        chk("midrst_joy2", 32'(bus.joy2_o), 32'h FFF);
        chk("midrst_p7", 32'(bus.joy_p7_o), 32'd1);
        chk("midrst_six1", 32'(bus.joy1_six_o), 32'd0);
        repeat (50) @(negedge clk_sys);
        chk("midrst_hold_frame", 32'(bus.frame_o), 32'd0);
        reset = 1'b0;
        wait_frame(c);
        chk("midrst_first_frame", 32'(c), 32'(7 * TD));
        chk("midrst_joy1_data", 32'(bus.joy1_o), 32'(exp_vec(K_MD6, b)));
        chk("midrst_six1_data", 32'(bus.joy1_six_o), 32'd1);
        chk("midrst_joy2_data", 32'(bus.joy2_o), 32'h FFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/joy_sega6_reader.md
Name: joy_sega6_reader

Overview:
- Upstream input stage for the arcade tops. Drives the shared select line (pin 7) of two DB9 joystick ports and reads Atari, Master System, Mega Drive 3-button and 6-button pads.
- Outputs per-port 12-bit active-low button vectors in the format MXYZ SACB RLDU. The top ORs these (inverted) with the keyboard-derived controls to build m_up/m_fire/btn_coin etc.
- Runs entirely on clk_sys with an internal tick divider. Does not clock from the video sync.

Parameters:
- TICK_DIV, 1536, clk_sys cycles per protocol tick (1536 gives 64 us at 24 MHz). Legal range 8..65535.
- SYNC_STAGES, 2, synchroniser depth on the DB9 input pins.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- joy1_pins_i  in  6  port 1 raw pins {p9,p6,right,left,down,up}, active low
- joy2_pins_i  in  6  port 2 raw pins, same order
- joy_p7_o  out  1  shared select line to both ports
- joy1_o  out  12  port 1 buttons {M,X,Y,Z,S,A,C,B,R,L,D,U}, 0 = pressed
- joy2_o  out  12  port 2 buttons, same format
- joy1_six_o  out  1  port 1 detected as 6-button this frame
- joy2_six_o  out  1  port 2 detected as 6-button
- frame_o  out  1  one-clk_sys pulse when the phase-6 update completes

Behaviour:

Reset values (asserted asynchronously):
- tick counter 0, phase counter 0, joy_p7_o=1.
- joy1_o/joy2_o=12'hFFF, six flags 0, frame_o=0, synchroniser flops 1.

Tick and phase sequencing:
- Tick counter counts 0..TICK_DIV-1 and wraps. The tick strobe is asserted when the count equals TICK_DIV-1.
- The 8-bit phase counter advances on each tick and wraps 255->0, so one frame is 256 ticks.
- All actions below occur on the tick clk_sys edge. They use the phase value before its increment and the synchronised pins.

Phase actions:
- Phase 0: p7<=0.
- Phase 1: p7<=1.
- Phase 2: latch [3:0]<=RLDU and [5:4]<={p9,p6} (C,B) for both ports. p7<=0. Clear the per-port internal six-candidate flags.
- Phase 3, per port:
  - If R=0 and L=0 (Mega Drive pad): [7:6]<={p9,p6} (Start,A).
  - Else: [7:6]<=2'b11 (Master System: A/B only).
  - p7<=1.
- Phase 4: p7<=0.
- Phase 5: per port, set six-candidate if U,D,L,R are all 0. p7<=1.
- Phase 6, per port:
  - If six-candidate: [11:8]<={R,L,D,U} (M,X,Y,Z).
  - Else: [11:8]<=4'hF.
  - joyN_six_o<=candidate.
  - frame_o pulses on the following cycle.
  - p7<=0.
- Phases 7..255: p7<=1. No register changes.

Output and timing rules:
- Output bits not written in a phase hold their value. Bits never glitch between updates.
- Each input pin is sampled at least TICK_DIV-SYNC_STAGES cycles after the last p7 change, which satisfies pad settle time.
- Latency: a pin change becomes visible within one frame plus SYNC_STAGES+1 clk_sys cycles.
- Ports are independent. A 6-button pad on port 1 and nothing on port 2 yields joy2_o=12'hFFF (R=L=1 in phase 3, so S/A=11).
- Reset mid-frame restarts at phase 0 with outputs released. There is no partial-frame output.

Decomposition:
- Package joy_pkg holds:
  - phase constants PH_P7_LO0=0 through PH_READ_XYZ=6;
  - bit indices JB_U=0 .. JB_M=11;
  - the released constant JOY_NONE=12'hFFF.
- Sub-module joy_pin_sync: a parameterised N-bit, SYNC_STAGES-deep synchroniser, reset to 1. Instantiated once over the 12 pins.

Test Plan (bench uses TICK_DIV=8; pad models are driven from joy_p7_o):
- No pad (all pins 1), run 2 frames -> joy1_o=joy2_o=12'hFFF, six flags 0, frame_o pulses once per 2048 cycles.
- 3-button MD model on port 1 with A and Up held -> joy1_o=12'hFBE (A=0, U=0), joy1_six_o=0.
- 6-button model on port 1 with X and C held -> joy1_o=12'hBDF, joy1_six_o=1. Port 2 idle stays 12'hFFF.
- Master System pad with p6 held (p7 ignored) -> [4]=0, [7:6]=11, [11:8]=F, i.e. 12'hFEF.
- Check joy_p7_o sequence over phases 0..7 -> 0,1,0,1,0,1,0,1, then constant 1 through phase 255, and phase wraps 255->0.
- Assert reset during phase 4 with 6-button pad active -> outputs immediately 12'hFFF, p7=1. After release, the first frame_o arrives after a full 7 ticks from phase 0 with correct data.
